weight_update: RTL
==================

WEIGHT_UPDATE -- requirements
Module: weight_update

Interface
REQ-001 SHALL have parameter N_FEAT, default 784, number of features (weights).
REQ-002 SHALL have parameter N_SAMP, default 40, number of training samples per epoch.
REQ-003 SHALL have parameter LR_SHIFT, default 12, learning-rate right shift applied to the gradient.
REQ-004 SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port start  input  1  one-cycle pulse that begins an epoch update.
REQ-007 SHALL have ports ycap_valid input 1 / ycap_ready output 1, handshake for the prediction stream.
REQ-008 SHALL have port ycap_data  input  10  unsigned Q2.8 sigmoid output (0..256).
REQ-009 SHALL have port label  input  1  target class of the sample, qualified by ycap_valid.
REQ-010 SHALL have ports x_valid input 1 / x_ready output 1, handshake for the pixel stream.
REQ-011 SHALL have port x_data  input  8  unsigned pixel value.
REQ-012 SHALL have port w_in  input  16  signed current weight for feature w_idx.
REQ-013 SHALL have port w_idx  output  10  index of the feature being processed.
REQ-014 SHALL have ports w_out output 16 (signed updated weight) and w_out_valid output 1.
REQ-015 SHALL have ports busy output 1 and done output 1 (one-cycle end-of-epoch pulse).

Function
REQ-016 SHALL implement states IDLE, LOAD_ERR, ACCUM, UPDATE, DONE.
REQ-017 IDLE -> LOAD_ERR on start; start SHALL be ignored in all other states.
REQ-018 In LOAD_ERR, ycap_ready SHALL be 1; each accepted beat SHALL store err[k] = ycap_data - (label ? 256 : 0) as 10-bit signed, k = 0..N_SAMP-1.
REQ-019 After beat N_SAMP-1 is accepted, the block SHALL enter ACCUM with w_idx = 0 and accumulator cleared.
REQ-020 In ACCUM, x_ready SHALL be 1; each accepted pixel j SHALL add err[j] * {1'b0,x_data} to a 26-bit signed accumulator, with one pixel accepted per cycle maximum.
REQ-021 x_valid low SHALL stall ACCUM with no change to the accumulator or sample counter.
REQ-022 After pixel N_SAMP-1 of a feature is accepted, the block SHALL enter UPDATE for exactly one cycle, with x_ready = 0 during that cycle.
REQ-023 In UPDATE, the block SHALL sample w_in and register w_out = w_in - (acc >>> LR_SHIFT) (arithmetic shift); w_out_valid SHALL be high the following cycle for exactly one cycle.
REQ-024 w_idx SHALL be stable from the first pixel of a feature through its UPDATE cycle; the exit from UPDATE SHALL increment w_idx and clear the accumulator and sample counter.
REQ-025 UPDATE with w_idx = N_FEAT-1 SHALL go to DONE; otherwise it SHALL return to ACCUM.
REQ-026 DONE SHALL assert done for one cycle, then return to IDLE.
REQ-027 busy SHALL be 1 in every state except IDLE; ycap_ready and x_ready SHALL be 0 outside LOAD_ERR and ACCUM respectively.
REQ-028 Latency from the last pixel accepted to w_out_valid SHALL be 2 cycles.

Reset
REQ-029 rst SHALL immediately force IDLE and clear all of the following: w_idx, counters, accumulator, err[], w_out = 0, w_out_valid = 0, done = 0, busy = 0, ycap_ready = 0, x_ready = 0.
REQ-030 rst asserted mid-epoch SHALL abort with no further w_out_valid pulses; a new start SHALL begin a fresh epoch.

Configuration
REQ-031 With WEIGHT_UPDATE_SAT_EN defined, the subtraction SHALL saturate to [-32768, 32767]; without it, the result SHALL wrap modulo 2^16.

Verification
REQ-032 N_SAMP=40 all ycap=256/label=1, any pixels, w_in=100 -> every w_out = 100, 784 w_out_valid pulses, then done.
REQ-033 ycap=384 label=0 (err=384), all x=255, LR_SHIFT=12, w_in=0 -> acc=3916800, w_out = -956.
REQ-034 ycap=0 label=1 (err=-256), x=255, w_in=32700 -> acc=-2611200, delta=-638: with SAT_EN w_out=32767; without it w_out=-32198.
REQ-035 Random x_valid gaps of 0-3 cycles -> results identical to the gap-free run; no pixel lost or duplicated.
REQ-036 rst pulse during ACCUM of feature 5 -> all outputs 0 next cycle, IDLE; a restart with start -> first w_out_valid corresponds to w_idx=0.
REQ-037 start asserted while busy -> ignored, epoch sequence unchanged.

Source files
------------

// File: rtl/weight_update.sv
// -----------------------------------------------------------------------------
// weight_update
//
// Logistic-regression weight update engine. Runs one epoch per start pulse.
//
// 1. LOAD_ERR: takes N_SAMP prediction beats and stores the signed error
//    err[k] = ycap - (label ? 1.0 : 0) for each one.
// 2. ACCUM: for each feature, streams in N_SAMP pixels and accumulates
//    sum_j err[j] * x[j].
// 3. UPDATE: produces w_out = w_in - (acc >>> LR_SHIFT).
//
// Parameters:
//   N_FEAT    number of features / weights (w_idx counts 0..N_FEAT-1)
//   N_SAMP    samples per epoch
//   LR_SHIFT  learning-rate right shift applied to the accumulated gradient
//
// Optional feature:
//   WEIGHT_UPDATE_SAT_EN  when defined, the weight subtraction saturates to
//                         the 16-bit signed range; otherwise it wraps.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   start                     one-cycle pulse, honoured only in IDLE
//   ycap_valid / ycap_ready   prediction stream handshake
//   ycap_data, label          Q2.8 sigmoid output and the target class
//   x_valid / x_ready         pixel stream handshake
//   x_data                    unsigned pixel
//   w_in / w_idx              current weight for feature w_idx
//   w_out / w_out_valid       updated weight, one-cycle valid strobe
//   busy, done                not-IDLE flag, one-cycle end-of-epoch pulse
// -----------------------------------------------------------------------------
module weight_update #(
  parameter int N_FEAT   = 784,
  parameter int N_SAMP   = 40,
  parameter int LR_SHIFT = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               ycap_valid,
  output logic               ycap_ready,
  input  logic [9:0]         ycap_data,
  input  logic               label,
  input  logic               x_valid,
  output logic               x_ready,
  input  logic [7:0]         x_data,
  input  logic signed [15:0] w_in,
  output logic [9:0]         w_idx,
  output logic signed [15:0] w_out,
  output logic               w_out_valid,
  output logic               busy,
  output logic               done
);

  localparam int CW = (N_SAMP > 1) ? $clog2(N_SAMP) : 1;
  localparam logic [CW-1:0] LAST_SAMP = CW'(N_SAMP - 1);
  localparam logic [9:0]    LAST_FEAT = 10'(N_FEAT - 1);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] LOAD_ERR = 3'd1;
  localparam logic [2:0] ACCUM    = 3'd2;
  localparam logic [2:0] UPDATE   = 3'd3;
  localparam logic [2:0] DONE     = 3'd4;

  logic [2:0]         state;
  logic [CW-1:0]      cnt;            // sample index within LOAD_ERR / ACCUM
  logic signed [9:0]  err_mem [N_SAMP];
  logic signed [25:0] acc;

  // The label subtracts 1.0 (256 in Q2.8). The 10-bit wrap reinterprets the
  // result as a signed value: ycap=0, label=1 gives -256.
  logic signed [9:0]  err_new;
  assign err_new = ycap_data - (label ? 10'd256 : 10'd0);

  // Pixels are unsigned, so a zero bit is prepended before the signed multiply.
  logic signed [18:0] prod;
  assign prod = err_mem[cnt] * $signed({1'b0, x_data});

  logic signed [25:0] acc_sh;
  logic signed [26:0] diff;
  logic signed [15:0] w_next;

  assign acc_sh = acc >>> LR_SHIFT;
  assign diff   = 27'(w_in) - 27'(acc_sh);

`ifdef WEIGHT_UPDATE_SAT_EN
  // NOTE: every branch assigns w_next, so no latch is inferred.
  always_comb begin
    if (diff > 27'sd32767)
      w_next = 16'sh7FFF;
    else if (diff < -27'sd32768)
      w_next = 16'sh8000;
    else
      w_next = diff[15:0];
  end
`else
  assign w_next = diff[15:0];
`endif

  // Error buffer.
  // NOTE: the buffer is cleared on reset as well, so an aborted epoch leaves
  // no stale errors behind. It is small enough that this is cheap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_SAMP; k++) err_mem[k] <= '0;
    end else if (state == LOAD_ERR && ycap_valid) begin
      err_mem[cnt] <= err_new;
    end
  end

  // Control, accumulator and output register.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side in this block reads the pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      acc         <= '0;
      w_idx       <= '0;
      w_out       <= '0;
      w_out_valid <= 1'b0;
    end else begin
      w_out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= LOAD_ERR;
            cnt   <= '0;
            acc   <= '0;
            w_idx <= '0;
          end
        end
        LOAD_ERR: begin
          if (ycap_valid) begin
            if (cnt == LAST_SAMP) begin
              state <= ACCUM;
              cnt   <= '0;
              acc   <= '0;
              w_idx <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ACCUM: begin
          if (x_valid) begin
            acc <= acc + 26'(prod);
            // cnt stays at LAST_SAMP here; it is cleared on the way out of
            // UPDATE.
            if (cnt == LAST_SAMP)
              state <= UPDATE;
            else
              cnt <= cnt + 1'b1;
          end
        end
        UPDATE: begin
          w_out       <= w_next;
          w_out_valid <= 1'b1;
          w_idx       <= w_idx + 1'b1;
          acc         <= '0;
          cnt         <= '0;
          state       <= (w_idx == LAST_FEAT) ? DONE : ACCUM;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign ycap_ready = (state == LOAD_ERR);
  assign x_ready    = (state == ACCUM);

endmodule
